data_bus_master_arbiter: RTL and testbench



---
 rtl/data_bus_pkg.sv | 25 ++
 rtl/rr_arbiter_2.sv | 32 +++
 rtl/data_bus_master_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_data_bus_master_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared types and widths for the two-master data bus arbiter.
// Imported by the arbiter top and its round-robin helper.
package data_bus_pkg;

    localparam int BE_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int INTG_W = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GNT  = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    function automatic master_t other_master(input master_t m);
        return (m == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way arbiter: a lone requester wins, ties go to M0 under
// fixed priority or otherwise to the master that was not served last.
module rr_arbiter_2
    import data_bus_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       req0,
    input  logic       req1,
    input  master_t    last_served,
    output logic [1:0] grant
);

    // One-hot tie-break between the two requesters
    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            if ((FIXED_PRIORITY != 0) || (other_master(last_served) == M0)) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/data_bus_master_arbiter.sv
// Shares one OBI/ibex-style data bus between two masters with a single
// outstanding transaction, owner-routed responses and an optional timeout.
module data_bus_master_arbiter
    import data_bus_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMER_WIDTH    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [BE_W-1:0]   m0_be,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [INTG_W-1:0] m0_wdata_intg,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [INTG_W-1:0] m0_rdata_intg,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [BE_W-1:0]   m1_be,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [INTG_W-1:0] m1_wdata_intg,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [INTG_W-1:0] m1_rdata_intg,
    output logic              m1_err,
    output logic              s_req,
    output logic              s_we,
    output logic [BE_W-1:0]   s_be,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [INTG_W-1:0] s_wdata_intg,
    input  logic              s_gnt,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [INTG_W-1:0] s_rdata_intg,
    input  logic              s_err
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
        TIMEOUT_EN ? TIMER_WIDTH'(TIMEOUT_CYCLES - 1) : {TIMER_WIDTH{1'b0}};

    arb_state_t             state_r,       state_nxt_s;
    master_t                owner_r,       owner_nxt_s;
    master_t                last_served_r, last_served_nxt_s;
    logic [TIMER_WIDTH-1:0] timer_r,       timer_nxt_s;

    logic [1:0]        arb_gnt_s;
    logic              fwd_en_s;
    master_t           fwd_sel_s;
    logic              gnt_s;
    logic              rsp_route_s;
    logic              rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_s;
    logic [INTG_W-1:0] rsp_intg_s;
    logic              rsp_err_s;

    rr_arbiter_2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_rr_arbiter_2 (
        .req0        (m0_req),
        .req1        (m1_req),
        .last_served (last_served_r),
        .grant       (arb_gnt_s)
    );

    // State, ownership and timeout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            owner_r       <= M0;
            last_served_r <= M1;
            timer_r       <= {TIMER_WIDTH{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            owner_r       <= owner_nxt_s;
            last_served_r <= last_served_nxt_s;
            timer_r       <= timer_nxt_s;
        end
    end

    // Next-state logic plus request-forward and response-routing selects
    always_comb begin
        state_nxt_s       = state_r;
        owner_nxt_s       = owner_r;
        last_served_nxt_s = last_served_r;
        timer_nxt_s       = timer_r;
        fwd_en_s          = 1'b0;
        fwd_sel_s         = owner_r;
        gnt_s             = 1'b0;
        rsp_route_s       = 1'b0;
        rsp_valid_s       = 1'b0;
        rsp_rdata_s       = {DATA_W{1'b0}};
        rsp_intg_s        = {INTG_W{1'b0}};
        rsp_err_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_gnt_s != 2'b00) begin
                    fwd_en_s    = 1'b1;
                    fwd_sel_s   = arb_gnt_s[1] ? M1 : M0;
                    gnt_s       = s_gnt;
                    owner_nxt_s = fwd_sel_s;
                    if (s_gnt) begin
                        last_served_nxt_s = fwd_sel_s;
                        timer_nxt_s       = {TIMER_WIDTH{1'b0}};
                        state_nxt_s       = WAIT_RESP;
                    end else begin
                        // OBI forbids withdrawing a pending request, so lock the winner
                        state_nxt_s = WAIT_GNT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_GNT: begin
                fwd_en_s  = 1'b1;
                fwd_sel_s = owner_r;
                gnt_s     = s_gnt;
                if (s_gnt) begin
                    last_served_nxt_s = owner_r;
                    timer_nxt_s       = {TIMER_WIDTH{1'b0}};
                    state_nxt_s       = WAIT_RESP;
                end else begin
                    state_nxt_s = WAIT_GNT;
                end
            end
            WAIT_RESP: begin
                rsp_route_s = 1'b1;
                rsp_rdata_s = s_rdata;
                rsp_intg_s  = s_rdata_intg;
                rsp_err_s   = s_err;
                if (s_rvalid) begin
                    rsp_valid_s = 1'b1;
                    state_nxt_s = IDLE;
                end else if (TIMEOUT_EN && (timer_r == TIMER_LAST)) begin
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = {DATA_W{1'b0}};
                    rsp_intg_s  = {INTG_W{1'b0}};
                    rsp_err_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    timer_nxt_s = timer_r + TIMER_WIDTH'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output muxing; everything is held at zero while reset is asserted
    always_comb begin
        s_req         = 1'b0;
        s_we          = 1'b0;
        s_be          = {BE_W{1'b0}};
        s_addr        = {ADDR_W{1'b0}};
        s_wdata       = {DATA_W{1'b0}};
        s_wdata_intg  = {INTG_W{1'b0}};
        m0_gnt        = 1'b0;
        m1_gnt        = 1'b0;
        m0_rvalid     = 1'b0;
        m0_rdata      = {DATA_W{1'b0}};
        m0_rdata_intg = {INTG_W{1'b0}};
        m0_err        = 1'b0;
        m1_rvalid     = 1'b0;
        m1_rdata      = {DATA_W{1'b0}};
        m1_rdata_intg = {INTG_W{1'b0}};
        m1_err        = 1'b0;
        if (!rst && fwd_en_s) begin
            if (fwd_sel_s == M1) begin
                s_req        = m1_req;
                s_we         = m1_we;
                s_be         = m1_be;
                s_addr       = m1_addr;
                s_wdata      = m1_wdata;
                s_wdata_intg = m1_wdata_intg;
                m1_gnt       = gnt_s;
            end else begin
                s_req        = m0_req;
                s_we         = m0_we;
                s_be         = m0_be;
                s_addr       = m0_addr;
                s_wdata      = m0_wdata;
                s_wdata_intg = m0_wdata_intg;
                m0_gnt       = gnt_s;
            end
        end else begin
            s_req = 1'b0;
        end
        if (!rst && rsp_route_s) begin
            if (owner_r == M1) begin
                m1_rvalid     = rsp_valid_s;
                m1_rdata      = rsp_rdata_s;
                m1_rdata_intg = rsp_intg_s;
                m1_err        = rsp_err_s;
            end else begin
                m0_rvalid     = rsp_valid_s;
                m0_rdata      = rsp_rdata_s;
                m0_rdata_intg = rsp_intg_s;
                m0_err        = rsp_err_s;
            end
        end else begin
            m0_rvalid = 1'b0;
        end
    end

endmodule

// File: tb/tb_data_bus_master_arbiter.sv
// Randomised scoreboard bench: a transaction-level model predicts grant and
// response cycles, a negedge monitor compares what the arbiters present.
module tb_data_bus_master_arbiter;

    localparam int TO_CYC = 8;

    typedef struct {
        int cyc;
        int mst;
    } gnt_exp_t;

    typedef struct {
        int          cyc;
        int          mst;
        logic [31:0] rd;
        logic [6:0]  ri;
        logic        er;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic m0_req, m0_we, m1_req, m1_we;
    logic [3:0] m0_be, m1_be;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [6:0] m0_wdata_intg, m1_wdata_intg;
    logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [6:0] m0_rdata_intg, m1_rdata_intg;
    logic s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [3:0] s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [6:0] s_wdata_intg, s_rdata_intg;

    logic fp_m0_req, fp_m1_req, fp_s_gnt, fp_s_rvalid;
    logic fp_m0_gnt, fp_m0_rvalid, fp_m0_err, fp_m1_gnt, fp_m1_rvalid, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
    logic [6:0] fp_m0_rdata_intg, fp_m1_rdata_intg, fp_s_wdata_intg;
    logic fp_s_req, fp_s_we;
    logic [3:0] fp_s_be;

    data_bus_master_arbiter #(
        .FIXED_PRIORITY (0),
        .TIMEOUT_CYCLES (TO_CYC),
        .TIMER_WIDTH    (16)
    ) dut (
        .clk (clk), .rst (rst),
        .m0_req (m0_req), .m0_we (m0_we), .m0_be (m0_be), .m0_addr (m0_addr),
        .m0_wdata (m0_wdata), .m0_wdata_intg (m0_wdata_intg),
        .m0_gnt (m0_gnt), .m0_rvalid (m0_rvalid), .m0_rdata (m0_rdata),
        .m0_rdata_intg (m0_rdata_intg), .m0_err (m0_err),
        .m1_req (m1_req), .m1_we (m1_we), .m1_be (m1_be), .m1_addr (m1_addr),
        .m1_wdata (m1_wdata), .m1_wdata_intg (m1_wdata_intg),
        .m1_gnt (m1_gnt), .m1_rvalid (m1_rvalid), .m1_rdata (m1_rdata),
        .m1_rdata_intg (m1_rdata_intg), .m1_err (m1_err),
        .s_req (s_req), .s_we (s_we), .s_be (s_be), .s_addr (s_addr),
        .s_wdata (s_wdata), .s_wdata_intg (s_wdata_intg),
        .s_gnt (s_gnt), .s_rvalid (s_rvalid), .s_rdata (s_rdata),
        .s_rdata_intg (s_rdata_intg), .s_err (s_err)
    );

    data_bus_master_arbiter #(
        .FIXED_PRIORITY (1),
        .TIMEOUT_CYCLES (0),
        .TIMER_WIDTH    (16)
    ) dut_fp (
        .clk (clk), .rst (rst),
        .m0_req (fp_m0_req), .m0_we (m0_we), .m0_be (m0_be), .m0_addr (m0_addr),
        .m0_wdata (m0_wdata), .m0_wdata_intg (m0_wdata_intg),
        .m0_gnt (fp_m0_gnt), .m0_rvalid (fp_m0_rvalid), .m0_rdata (fp_m0_rdata),
        .m0_rdata_intg (fp_m0_rdata_intg), .m0_err (fp_m0_err),
        .m1_req (fp_m1_req), .m1_we (m1_we), .m1_be (m1_be), .m1_addr (m1_addr),
        .m1_wdata (m1_wdata), .m1_wdata_intg (m1_wdata_intg),
        .m1_gnt (fp_m1_gnt), .m1_rvalid (fp_m1_rvalid), .m1_rdata (fp_m1_rdata),
        .m1_rdata_intg (fp_m1_rdata_intg), .m1_err (fp_m1_err),
        .s_req (fp_s_req), .s_we (fp_s_we), .s_be (fp_s_be), .s_addr (fp_s_addr),
        .s_wdata (fp_s_wdata), .s_wdata_intg (fp_s_wdata_intg),
        .s_gnt (fp_s_gnt), .s_rvalid (fp_s_rvalid), .s_rdata (s_rdata),
        .s_rdata_intg (s_rdata_intg), .s_err (s_err)
    );

    int cyc_cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;
    gnt_exp_t gnt_q[$];
    rsp_exp_t rsp_q[$];
    gnt_exp_t fp_gnt_q[$];
    gnt_exp_t fp_rsp_q[$];
    logic [76:0] exp_fwd = '0;

    // Model of each master's pending request and the arbitration history
    bit          pend[2];
    logic        req_we[2];
    logic [3:0]  req_be[2];
    logic [31:0] req_addr[2];
    logic [31:0] req_wdata[2];
    logic [6:0]  req_intg[2];
    int          last_served = 1;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    function automatic logic [76:0] fwd_vec(input int m);
        return {1'b1, req_we[m], req_be[m], req_addr[m], req_wdata[m], req_intg[m]};
    endfunction

    function automatic logic [81:0] rsp_vec(input rsp_exp_t e);
        logic [40:0] f;
        f = {1'b1, e.rd, e.ri, e.er};
        return (e.mst == 0) ? {f, 41'd0} : {41'd0, f};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int m);
        pend[m]      = 1'b1;
        req_we[m]    = 1'($urandom_range(0, 1));
        req_be[m]    = 4'($urandom_range(1, 15));
        req_addr[m]  = $urandom & 32'hFFFF_FFFC;
        req_wdata[m] = $urandom;
        req_intg[m]  = 7'($urandom);
    endtask

    task automatic drive_masters(input bit a0, input bit a1);
        m0_req = a0; m0_we = req_we[0]; m0_be = req_be[0]; m0_addr = req_addr[0];
        m0_wdata = req_wdata[0]; m0_wdata_intg = req_intg[0];
        m1_req = a1; m1_we = req_we[1]; m1_be = req_be[1]; m1_addr = req_addr[1];
        m1_wdata = req_wdata[1]; m1_wdata_intg = req_intg[1];
    endtask

    // One transaction: request, gd stall cycles, grant, then lat cycles to the
    // response (lat >= TO_CYC means the slave never answers).
    task automatic do_txn(input bit n0, input bit n1, input int gd, input int lat,
                          input bit m0_late, input logic [31:0] rd, input bit er);
        bit fresh0, late;
        int w, c;
        rsp_exp_t r;
        fresh0 = 1'b0;
        if (n0 && !pend[0]) begin new_req(0); fresh0 = 1'b1; end
        if (n1 && !pend[1]) new_req(1);
        if (!pend[0] && !pend[1]) begin new_req(0); fresh0 = 1'b1; end
        late = m0_late && fresh0 && pend[1] && (gd > 0);
        if (pend[0] && !late && pend[1]) w = (last_served == 0) ? 1 : 0;
        else if (pend[0] && !late) w = 0;
        else w = 1;
        drive_masters(pend[0] && !late, pend[1]);
        exp_fwd = fwd_vec(w);
        s_gnt = 1'b0;
        for (int i = 0; i < gd; i++) begin
            next_cycle();
            drive_masters(pend[0], pend[1]);
        end
        s_gnt = 1'b1;
        gnt_q.push_back('{cyc: cyc_cnt, mst: w});
        next_cycle();
        s_gnt = 1'b0;
        pend[w] = 1'b0;
        last_served = w;
        drive_masters(pend[0], pend[1]);
        exp_fwd = '0;
        c = cyc_cnt;
        if (lat < TO_CYC) begin
            repeat (lat) next_cycle();
            r = '{cyc: cyc_cnt, mst: w, rd: rd, ri: 7'($urandom), er: er};
            rsp_q.push_back(r);
            s_rvalid = 1'b1; s_rdata = rd; s_rdata_intg = r.ri; s_err = er;
            next_cycle();
            s_rvalid = 1'b0; s_rdata = $urandom; s_err = 1'($urandom_range(0, 1));
        end else begin
            rsp_q.push_back('{cyc: c + TO_CYC - 1, mst: w, rd: 32'd0, ri: 7'd0, er: 1'b1});
            s_rdata = $urandom;
            repeat (TO_CYC) next_cycle();
            drive_masters(1'b0, 1'b0);
            next_cycle();
            s_rvalid = 1'b1;
            next_cycle();
            s_rvalid = 1'b0;
        end
    endtask

    // Monitor: compare every presented grant/response with the scoreboard
    initial begin
        gnt_exp_t g;
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_m_outputs", {m0_gnt, m0_rvalid, m0_rdata, m0_rdata_intg, m0_err,
                     m1_gnt, m1_rvalid, m1_rdata, m1_rdata_intg, m1_err}, '0);
                chk("rst_s_outputs", {s_req, s_we, s_be, s_addr, s_wdata, s_wdata_intg}, '0);
                chk("rst_fp_m_outputs", {fp_m0_gnt, fp_m0_rvalid, fp_m0_rdata, fp_m0_rdata_intg,
                     fp_m0_err, fp_m1_gnt, fp_m1_rvalid, fp_m1_rdata, fp_m1_rdata_intg,
                     fp_m1_err}, '0);
                chk("rst_fp_s_outputs", {fp_s_req, fp_s_we, fp_s_be, fp_s_addr, fp_s_wdata,
                     fp_s_wdata_intg}, '0);
            end else begin
                chk("fwd", {s_req, s_we, s_be, s_addr, s_wdata, s_wdata_intg}, exp_fwd);
                if (m0_gnt || m1_gnt) begin
                    if (gnt_q.size() == 0) chk("gnt_unexpected", {m0_gnt, m1_gnt}, '0);
                    else begin
                        g = gnt_q.pop_front();
                        chk("gnt", {cyc_cnt, m1_gnt, m0_gnt},
                            {g.cyc, (g.mst == 1), (g.mst == 0)});
                    end
                end
                if (m0_rvalid || m1_rvalid) begin
                    if (rsp_q.size() == 0) chk("rvalid_unexpected", {m0_rvalid, m1_rvalid}, '0);
                    else begin
                        r = rsp_q.pop_front();
                        chk("rsp", {cyc_cnt, m0_rvalid, m0_rdata, m0_rdata_intg, m0_err,
                             m1_rvalid, m1_rdata, m1_rdata_intg, m1_err}, {r.cyc, rsp_vec(r)});
                    end
                end
                if (fp_m0_gnt || fp_m1_gnt) begin
                    if (fp_gnt_q.size() == 0) chk("fp_gnt_unexpected", {fp_m0_gnt, fp_m1_gnt}, '0);
                    else begin
                        g = fp_gnt_q.pop_front();
                        chk("fp_gnt", {cyc_cnt, fp_m1_gnt, fp_m0_gnt},
                            {g.cyc, (g.mst == 1), (g.mst == 0)});
                    end
                end
                if (fp_m0_rvalid || fp_m1_rvalid) begin
                    if (fp_rsp_q.size() == 0) chk("fp_rvalid_unexpected", {fp_m0_rvalid, fp_m1_rvalid}, '0);
                    else begin
                        g = fp_rsp_q.pop_front();
                        chk("fp_rsp", {cyc_cnt, fp_m1_rvalid, fp_m0_rvalid},
                            {g.cyc, (g.mst == 1), (g.mst == 0)});
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        new_req(0); new_req(1);
        pend[0] = 1'b0; pend[1] = 1'b0;
        fp_m0_req = 1'b0; fp_m1_req = 1'b0; fp_s_gnt = 1'b0; fp_s_rvalid = 1'b0;
        drive_masters(1'b1, 1'b1);
        s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = $urandom; s_rdata_intg = 7'($urandom); s_err = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b0;
        drive_masters(1'b0, 1'b0);
        s_gnt = 1'b0; s_rvalid = 1'b0;
        next_cycle();

        for (int k = 0; k < 4; k++) do_txn(1'b1, 1'b1, 0, 0, 1'b0, $urandom, 1'b0);
        do_txn(1'b1, 1'b0, 0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        do_txn(1'b1, 1'b1, 3, 1, 1'b1, $urandom, 1'b0);
        do_txn(1'b0, 1'b0, 0, 0, 1'b0, $urandom, 1'b1);
        do_txn(1'b1, 1'b0, 0, 99, 1'b0, $urandom, 1'b0);
        do_txn(1'b1, 1'b0, 0, TO_CYC - 1, 1'b0, 32'h0000_1234, 1'b0);

        // Reset pulse while a transaction waits for its response
        drive_masters(1'b0, 1'b0);
        pend[0] = 1'b0; pend[1] = 1'b0;
        new_req(0);
        drive_masters(1'b1, 1'b0);
        exp_fwd = fwd_vec(0);
        s_gnt = 1'b1;
        gnt_q.push_back('{cyc: cyc_cnt, mst: 0});
        next_cycle();
        s_gnt = 1'b0; pend[0] = 1'b0;
        drive_masters(1'b0, 1'b0);
        exp_fwd = '0;
        next_cycle();
        rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1; s_rvalid = 1'b1;
        next_cycle();
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0;
        last_served = 1;
        next_cycle();
        s_rvalid = 1'b0;
        do_txn(1'b0, 1'b1, 1, 1, 1'b0, $urandom, 1'b0);

        for (int k = 0; k < 60; k++) begin
            int sel, lat;
            sel = $urandom_range(0, 9);
            lat = (sel < 4) ? sel : (sel < 6) ? TO_CYC - 1 : (sel < 8) ? $urandom_range(0, 2) : 99;
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   lat, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                drive_masters(1'b0, 1'b0);
                exp_fwd = '0;
                repeat ($urandom_range(1, 2)) next_cycle();
            end
        end
        drive_masters(1'b0, 1'b0);
        exp_fwd = '0;
        next_cycle();

        // Fixed-priority instance: M0 wins every tie, M1 only once M0 stops
        fp_m0_req = 1'b1; fp_m1_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) fp_m0_req = 1'b0;
            fp_s_gnt = 1'b1;
            fp_gnt_q.push_back('{cyc: cyc_cnt, mst: (k == 4) ? 1 : 0});
            next_cycle();
            fp_s_gnt = 1'b0; fp_s_rvalid = 1'b1;
            if (k == 4) fp_m1_req = 1'b0;
            fp_rsp_q.push_back('{cyc: cyc_cnt, mst: (k == 4) ? 1 : 0});
            next_cycle();
            fp_s_rvalid = 1'b0;
        end
        repeat (3) next_cycle();

        chk("gnt_q_drained", 128'(gnt_q.size()), '0);
        chk("rsp_q_drained", 128'(rsp_q.size()), '0);
        chk("fp_gnt_q_drained", 128'(fp_gnt_q.size()), '0);
        chk("fp_rsp_q_drained", 128'(fp_rsp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
